// File: rtl/bmd_axist_cc_arbiter.sv
// Packet-atomic round-robin arbiter merging two CC AXI-Stream completion sources
// into one 512b stream, with a 2-entry output FIFO that breaks the tready path.
module bmd_axist_cc_arbiter #(
   parameter int unsigned DATA_W = 512,
   parameter int unsigned KEEP_W = 16,
   parameter int unsigned USER_W = 81,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              user_clk,
   input  logic              user_reset,
   input  logic [DATA_W-1:0] s_axis_cc0_tdata,
   input  logic [KEEP_W-1:0] s_axis_cc0_tkeep,
   input  logic [USER_W-1:0] s_axis_cc0_tuser,
   input  logic              s_axis_cc0_tlast,
   input  logic              s_axis_cc0_tvalid,
   output logic              s_axis_cc0_tready,
   input  logic [DATA_W-1:0] s_axis_cc1_tdata,
   input  logic [KEEP_W-1:0] s_axis_cc1_tkeep,
   input  logic [USER_W-1:0] s_axis_cc1_tuser,
   input  logic              s_axis_cc1_tlast,
   input  logic              s_axis_cc1_tvalid,
   output logic              s_axis_cc1_tready,
   output logic [DATA_W-1:0] m_axis_cc_tdata,
   output logic [KEEP_W-1:0] m_axis_cc_tkeep,
   output logic [USER_W-1:0] m_axis_cc_tuser,
   output logic              m_axis_cc_tlast,
   output logic              m_axis_cc_tvalid,
   input  logic              m_axis_cc_tready,
   output logic [CNT_W-1:0]  pkt_cnt0,
   output logic [CNT_W-1:0]  pkt_cnt1,
   output logic              straddle_err
);

   // is_sop[1] position inside the packed CC tuser
   localparam int unsigned SOP1_BIT = 1;

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   state_t            state;
   state_t            state_n;
   logic              rr_last;    // 1: req1 finished the last packet
   logic              mid_pkt;    // a packet of the granted source is in flight
   logic [1:0]        fifo_cnt;
   logic [1:0]        cnt_n;

   // second FIFO entry; the head entry is the m_axis_cc_* register set itself
   logic [DATA_W-1:0] tail_data;
   logic [KEEP_W-1:0] tail_keep;
   logic [USER_W-1:0] tail_user;
   logic              tail_last;

   logic              acc0;
   logic              acc1;
   logic              push;
   logic              pop;
   logic              sel1;
   logic [DATA_W-1:0] in_data;
   logic [KEEP_W-1:0] in_keep;
   logic [USER_W-1:0] in_user;
   logic              in_last;

   // handshakes and the granted source's beat
   always_comb begin
      acc0    = s_axis_cc0_tvalid & s_axis_cc0_tready;
      acc1    = s_axis_cc1_tvalid & s_axis_cc1_tready;
      push    = acc0 | acc1;
      pop     = m_axis_cc_tvalid & m_axis_cc_tready;
      sel1    = (state == LOCK1);
      in_data = sel1 ? s_axis_cc1_tdata : s_axis_cc0_tdata;
      in_keep = sel1 ? s_axis_cc1_tkeep : s_axis_cc0_tkeep;
      in_user = sel1 ? s_axis_cc1_tuser : s_axis_cc0_tuser;
      in_last = sel1 ? s_axis_cc1_tlast : s_axis_cc0_tlast;
   end

   // FIFO occupancy after this cycle's push/pop
   always_comb begin
      cnt_n = fifo_cnt;
      if (push && !pop)
         cnt_n = fifo_cnt + 2'd1;
      else if (!push && pop)
         cnt_n = fifo_cnt - 2'd1;
   end

   // grant selection; a lock is released only at a packet boundary
   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (s_axis_cc0_tvalid && s_axis_cc1_tvalid)
               state_n = rr_last ? LOCK0 : LOCK1;
            else if (s_axis_cc0_tvalid)
               state_n = LOCK0;
            else if (s_axis_cc1_tvalid)
               state_n = LOCK1;
         end
         LOCK0: begin
            if (acc0 && s_axis_cc0_tlast) begin
               if (s_axis_cc1_tvalid)      state_n = LOCK1;
               else if (s_axis_cc0_tvalid) state_n = LOCK0;
               else                        state_n = IDLE;
            end else if (!mid_pkt && !s_axis_cc0_tvalid) begin
               // parked between packets with nothing pending from the owner
               state_n = s_axis_cc1_tvalid ? LOCK1 : IDLE;
            end
         end
         LOCK1: begin
            if (acc1 && s_axis_cc1_tlast) begin
               if (s_axis_cc0_tvalid)      state_n = LOCK0;
               else if (s_axis_cc1_tvalid) state_n = LOCK1;
               else                        state_n = IDLE;
            end else if (!mid_pkt && !s_axis_cc1_tvalid) begin
               state_n = s_axis_cc0_tvalid ? LOCK0 : IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // state, registered handshakes, FIFO storage, counters and error flag
   always_ff @(posedge user_clk or posedge user_reset) begin
      if (user_reset) begin
         state             <= IDLE;
         rr_last           <= 1'b1;
         mid_pkt           <= 1'b0;
         fifo_cnt          <= 2'd0;
         s_axis_cc0_tready <= 1'b0;
         s_axis_cc1_tready <= 1'b0;
         m_axis_cc_tvalid  <= 1'b0;
         m_axis_cc_tdata   <= '0;
         m_axis_cc_tkeep   <= '0;
         m_axis_cc_tuser   <= '0;
         m_axis_cc_tlast   <= 1'b0;
         tail_data         <= '0;
         tail_keep         <= '0;
         tail_user         <= '0;
         tail_last         <= 1'b0;
         pkt_cnt0          <= '0;
         pkt_cnt1          <= '0;
         straddle_err      <= 1'b0;
      end else begin
         state             <= state_n;
         fifo_cnt          <= cnt_n;
         s_axis_cc0_tready <= (state_n == LOCK0) && (cnt_n != 2'd2);
         s_axis_cc1_tready <= (state_n == LOCK1) && (cnt_n != 2'd2);
         m_axis_cc_tvalid  <= (cnt_n != 2'd0);

         if (acc0 && s_axis_cc0_tlast) begin
            rr_last  <= 1'b0;
            pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
         end
         if (acc1 && s_axis_cc1_tlast) begin
            rr_last  <= 1'b1;
            pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
         end
         if (push) begin
            mid_pkt <= ~in_last;
            if (in_user[SOP1_BIT])
               straddle_err <= 1'b1;
         end

         if (pop) begin
            if (push && (fifo_cnt == 2'd1)) begin
               m_axis_cc_tdata <= in_data;
               m_axis_cc_tkeep <= in_keep;
               m_axis_cc_tuser <= in_user;
               m_axis_cc_tlast <= in_last;
            end else begin
               m_axis_cc_tdata <= tail_data;
               m_axis_cc_tkeep <= tail_keep;
               m_axis_cc_tuser <= tail_user;
               m_axis_cc_tlast <= tail_last;
            end
         end else if (push) begin
            if (fifo_cnt == 2'd0) begin
               m_axis_cc_tdata <= in_data;
               m_axis_cc_tkeep <= in_keep;
               m_axis_cc_tuser <= in_user;
               m_axis_cc_tlast <= in_last;
            end else begin
               tail_data <= in_data;
               tail_keep <= in_keep;
               tail_user <= in_user;
               tail_last <= in_last;
            end
         end
      end
   end

endmodule

// File: tb/tb_bmd_axist_cc_arbiter.sv
// Directed bench for bmd_axist_cc_arbiter: per-cycle vector table plus
// hand-written straddle and mid-packet reset sequences.
module tb_bmd_axist_cc_arbiter;

   localparam int unsigned DATA_W = 512;
   localparam int unsigned KEEP_W = 16;
   localparam int unsigned USER_W = 81;
   localparam int unsigned CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] s0_data, s1_data, m_data;
   logic [KEEP_W-1:0] s0_keep, s1_keep, m_keep;
   logic [USER_W-1:0] s0_user, s1_user, m_user;
   logic              s0_last, s0_valid, s0_ready;
   logic              s1_last, s1_valid, s1_ready;
   logic              m_last, m_valid, m_ready;
   logic [CNT_W-1:0]  cnt0, cnt1;
   logic              serr;

   bmd_axist_cc_arbiter #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W), .CNT_W(CNT_W)) dut (
      .user_clk(clk), .user_reset(rst),
      .s_axis_cc0_tdata(s0_data), .s_axis_cc0_tkeep(s0_keep), .s_axis_cc0_tuser(s0_user),
      .s_axis_cc0_tlast(s0_last), .s_axis_cc0_tvalid(s0_valid), .s_axis_cc0_tready(s0_ready),
      .s_axis_cc1_tdata(s1_data), .s_axis_cc1_tkeep(s1_keep), .s_axis_cc1_tuser(s1_user),
      .s_axis_cc1_tlast(s1_last), .s_axis_cc1_tvalid(s1_valid), .s_axis_cc1_tready(s1_ready),
      .m_axis_cc_tdata(m_data), .m_axis_cc_tkeep(m_keep), .m_axis_cc_tuser(m_user),
      .m_axis_cc_tlast(m_last), .m_axis_cc_tvalid(m_valid), .m_axis_cc_tready(m_ready),
      .pkt_cnt0(cnt0), .pkt_cnt1(cnt1), .straddle_err(serr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v0;  logic [15:0] d0; logic l0;
      logic        v1;  logic [15:0] d1; logic l1;
      logic        mr;
      logic        er0; logic er1; logic emv; logic [15:0] emd; logic eml;
      logic [15:0] ec0; logic [15:0] ec1;
   } vec_t;

   vec_t vt[64];
   int   nv    = 0;
   int   n_vec = 0;
   int   n_err = 0;

   function automatic logic [USER_W-1:0] mkuser(input logic [15:0] d);
      logic [USER_W-1:0] u;
      u       = '0;
      u[15:2] = d[15:2];   // is_sop bits kept 0 for well-formed traffic
      return u;
   endfunction

   task automatic add(input logic v0, input logic [15:0] d0, input logic l0,
                      input logic v1, input logic [15:0] d1, input logic l1, input logic mr,
                      input logic er0, input logic er1, input logic emv, input logic [15:0] emd,
                      input logic eml, input logic [15:0] ec0, input logic [15:0] ec1);
      vt[nv] = '{v0, d0, l0, v1, d1, l1, mr, er0, er1, emv, emd, eml, ec0, ec1};
      nv++;
   endtask

   task automatic drv0(input logic v, input logic [15:0] d, input logic l);
      s0_valid = v; s0_data = v ? {32{d}} : '0; s0_keep = v ? d : '0;
      s0_user  = v ? mkuser(d) : '0; s0_last = v & l;
   endtask

   task automatic drv1(input logic v, input logic [15:0] d, input logic l);
      s1_valid = v; s1_data = v ? {32{d}} : '0; s1_keep = v ? d : '0;
      s1_user  = v ? mkuser(d) : '0; s1_last = v & l;
   endtask

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h expected=%h", nm, got, exp);
      end
   endtask

   // wait (bounded) until the chosen source sees tready at a negedge
   task automatic wait_rdy(input bit src1, input string nm);
      int i;
      for (i = 0; i < 20; i++) begin
         if ((src1 ? s1_ready : s0_ready) === 1'b1) break;
         @(negedge clk);
      end
      if (i == 20) chk({nm, "_timeout"}, 128'd0, 128'd1);
   endtask

   logic [DATA_W-1:0] rdata;
   logic [USER_W-1:0] ruser;
   logic [KEEP_W-1:0] rkeep;
   logic              dok;

   initial begin
      rst = 1'b1; m_ready = 1'b1;
      drv0(1'b0, 16'h0, 1'b0);
      drv1(1'b0, 16'h0, 1'b0);
      repeat (3) @(negedge clk);
      chk("reset_state", {s0_ready, s1_ready, m_valid, m_last, serr,
                          m_data == '0, m_keep == '0, m_user == '0, cnt0, cnt1},
          {5'b0, 3'b111, 32'd0});
      rst = 1'b0;

      // both sources from reset, 2-beat packets back-to-back: A1 A2 B1 B2 A3 A4 B3 B4
      add(1,'hA1,0, 1,'hB1,0, 1,  0,0,0,'h00,0, 0,0);
      add(1,'hA1,0, 1,'hB1,0, 1,  1,0,0,'h00,0, 0,0);
      add(1,'hA2,1, 1,'hB1,0, 1,  1,0,1,'hA1,0, 0,0);
      add(1,'hA3,0, 1,'hB1,0, 1,  0,1,1,'hA2,1, 1,0);
      add(1,'hA3,0, 1,'hB2,1, 1,  0,1,1,'hB1,0, 1,0);
      add(1,'hA3,0, 1,'hB3,0, 1,  1,0,1,'hB2,1, 1,1);
      add(1,'hA4,1, 1,'hB3,0, 1,  1,0,1,'hA3,0, 1,1);
      add(0,'h00,0, 1,'hB3,0, 1,  0,1,1,'hA4,1, 2,1);
      add(0,'h00,0, 1,'hB4,1, 1,  0,1,1,'hB3,0, 2,1);
      add(0,'h00,0, 0,'h00,0, 1,  0,1,1,'hB4,1, 2,2);
      add(0,'h00,0, 0,'h00,0, 1,  0,0,0,'h00,0, 2,2);
      // req0 only, 3-beat packet, one-cycle latency
      add(1,'h11,0, 0,'h00,0, 1,  0,0,0,'h00,0, 2,2);
      add(1,'h11,0, 0,'h00,0, 1,  1,0,0,'h00,0, 2,2);
      add(1,'h12,0, 0,'h00,0, 1,  1,0,1,'h11,0, 2,2);
      add(1,'h13,1, 0,'h00,0, 1,  1,0,1,'h12,0, 2,2);
      add(0,'h00,0, 0,'h00,0, 1,  1,0,1,'h13,1, 3,2);
      add(0,'h00,0, 0,'h00,0, 1,  0,0,0,'h00,0, 3,2);
      // req1 raises tvalid during req0's 4-beat packet
      add(1,'hC1,0, 0,'h00,0, 1,  0,0,0,'h00,0, 3,2);
      add(1,'hC1,0, 0,'h00,0, 1,  1,0,0,'h00,0, 3,2);
      add(1,'hC2,0, 1,'hD1,0, 1,  1,0,1,'hC1,0, 3,2);
      add(1,'hC3,0, 1,'hD1,0, 1,  1,0,1,'hC2,0, 3,2);
      add(1,'hC4,1, 1,'hD1,0, 1,  1,0,1,'hC3,0, 3,2);
      add(0,'h00,0, 1,'hD1,0, 1,  0,1,1,'hC4,1, 4,2);
      add(0,'h00,0, 1,'hD2,1, 1,  0,1,1,'hD1,0, 4,2);
      add(0,'h00,0, 0,'h00,0, 1,  0,1,1,'hD2,1, 4,3);
      add(0,'h00,0, 0,'h00,0, 1,  0,0,0,'h00,0, 4,3);
      // output stalled 5 cycles mid-packet: FIFO fills, source held off, head stable
      add(1,'hE1,0, 0,'h00,0, 1,  0,0,0,'h00,0, 4,3);
      add(1,'hE1,0, 0,'h00,0, 0,  1,0,0,'h00,0, 4,3);
      add(1,'hE2,0, 0,'h00,0, 0,  1,0,1,'hE1,0, 4,3);
      add(1,'hE3,0, 0,'h00,0, 0,  0,0,1,'hE1,0, 4,3);
      add(1,'hE3,0, 0,'h00,0, 0,  0,0,1,'hE1,0, 4,3);
      add(1,'hE3,0, 0,'h00,0, 0,  0,0,1,'hE1,0, 4,3);
      add(1,'hE3,0, 0,'h00,0, 1,  0,0,1,'hE1,0, 4,3);
      add(1,'hE3,0, 0,'h00,0, 1,  1,0,1,'hE2,0, 4,3);
      add(1,'hE4,1, 0,'h00,0, 1,  1,0,1,'hE3,0, 4,3);
      add(0,'h00,0, 0,'h00,0, 1,  1,0,1,'hE4,1, 5,3);
      add(0,'h00,0, 0,'h00,0, 1,  0,0,0,'h00,0, 5,3);

      for (int i = 0; i < nv; i++) begin
         @(negedge clk);
         drv0(vt[i].v0, vt[i].d0, vt[i].l0);
         drv1(vt[i].v1, vt[i].d1, vt[i].l1);
         m_ready = vt[i].mr;
         dok = !m_valid || (m_data == {32{vt[i].emd}} && m_keep == vt[i].emd &&
                            m_user == mkuser(vt[i].emd));
         chk($sformatf("vec%0d", i),
             {s0_ready, s1_ready, m_valid, m_valid ? m_data[15:0] : 16'h0,
              m_valid & m_last, dok, cnt0, cnt1},
             {vt[i].er0, vt[i].er1, vt[i].emv, vt[i].emv ? vt[i].emd : 16'h0,
              vt[i].emv & vt[i].eml, 1'b1, vt[i].ec0, vt[i].ec1});
      end

      // straddled beat from req1: forwarded verbatim, sticky error flag
      @(negedge clk);
      for (int k = 0; k < 16; k++) rdata[k*32 +: 32] = $urandom;
      ruser = {$urandom, $urandom, $urandom};
      ruser[1:0] = 2'b11;
      rkeep = 16'hFFFF;
      s1_valid = 1'b1; s1_data = rdata; s1_keep = rkeep; s1_user = ruser; s1_last = 1'b1;
      @(negedge clk);
      wait_rdy(1'b1, "straddle");
      @(negedge clk);
      drv1(1'b0, 16'h0, 1'b0);
      chk("straddle_fwd", {m_valid, m_last, m_data == rdata, m_keep == rkeep, m_user == ruser, serr},
          {6'b111111});
      repeat (4) @(negedge clk);
      chk("straddle_sticky", {serr, m_valid, cnt1}, {1'b1, 1'b0, 16'd4});

      // reset during beat 2 of a 3-beat req0 packet
      drv0(1'b1, 16'hF1, 1'b0);
      @(negedge clk);
      wait_rdy(1'b0, "rst_beat1");
      @(negedge clk);
      drv0(1'b1, 16'hF2, 1'b0);
      chk("rst_beat2_ready", {s0_ready, m_valid, m_data[15:0]}, {1'b1, 1'b1, 16'hF1});
      rst = 1'b1;
      @(negedge clk);
      chk("rst_outputs", {s0_ready, s1_ready, m_valid, m_last, serr,
                          m_data == '0, m_keep == '0, m_user == '0, cnt0, cnt1},
          {5'b0, 3'b111, 32'd0});
      rst = 1'b0;
      drv0(1'b0, 16'h0, 1'b0);
      drv1(1'b1, 16'h61, 1'b1);
      @(negedge clk);
      wait_rdy(1'b1, "post_rst");
      @(negedge clk);
      drv1(1'b0, 16'h0, 1'b0);
      chk("post_rst_pkt", {m_valid, m_last, m_data == {32{16'h61}}, s0_ready}, {4'b1110});
      @(negedge clk);
      chk("post_rst_cnt", {m_valid, cnt0, cnt1}, {1'b0, 16'd0, 16'd1});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
